// File: rtl/stream_reducer.sv
// Stream reducer: launches an upstream generator, folds every accepted data beat
// into sum/count/max, then holds the result on a valid/ready output port.
module stream_reducer #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    output logic                 gen_start_o,
    input  logic                 in_valid_i,
    input  logic                 in_done_i,
    input  logic [WIDTH-1:0]     in_data_i,
    output logic                 in_ready_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH-1:0]     out_sum_o,
    output logic [CNT_WIDTH-1:0] out_count_o,
    output logic [WIDTH-1:0]     out_max_o,
    output logic                 overflow_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {IDLE, LAUNCH, COLLECT, REPORT} state_t;

    state_t               state_q;
    logic                 gen_start_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 overflow_q;
    logic                 busy_q;
    logic [WIDTH-1:0]     sum_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0]     max_q;

    logic [WIDTH:0]       add_d;
    logic [WIDTH-1:0]     sum_d;
    logic                 carry_d;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0]     max_d;
    logic                 beat_acc;

    // in_ready_q is only ever set in COLLECT, so acceptance needs no state decode.
    always_comb begin
        add_d    = {1'b0, sum_q} + {1'b0, in_data_i};
        sum_d    = add_d[WIDTH-1:0];
        carry_d  = add_d[WIDTH];
        cnt_d    = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        max_d    = (in_data_i > max_q) ? in_data_i : max_q;
        beat_acc = in_ready_q && in_valid_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            gen_start_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            sum_q       <= '0;
            cnt_q       <= '0;
            max_q       <= '0;
        end else begin
            gen_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q     <= LAUNCH;
                        gen_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                LAUNCH: begin
                    sum_q      <= '0;
                    cnt_q      <= '0;
                    max_q      <= '0;
                    overflow_q <= 1'b0;
                    in_ready_q <= 1'b1;
                    state_q    <= COLLECT;
                end
                COLLECT: begin
                    if (beat_acc) begin
                        if (in_done_i) begin
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= REPORT;
                        end else begin
                            sum_q      <= sum_d;
                            overflow_q <= overflow_q | carry_d;
                            cnt_q      <= cnt_d;
                            max_q      <= max_d;
                        end
                    end
                end
                REPORT: begin
                    // start is deliberately not looked at here, even on the exit cycle.
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign gen_start_o = gen_start_q;
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_sum_o   = sum_q;
    assign out_count_o = cnt_q;
    assign out_max_o   = max_q;
    assign overflow_o  = overflow_q;
    assign busy_o      = busy_q;

endmodule
